// File: rtl/core_pkg.sv
// Shared types for the pipeline hazard unit.
// Contents: register-address width, forwarding-select encoding, shadow pipeline
// stage payloads (destination info for every stage, source info for EX only).
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Destination bookkeeping carried by every shadow stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } shadow_stage_t;

    // Source operands of the instruction sitting in EX
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } ex_src_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bus between the datapath and the hazard unit.
// master: datapath side (drives ID decode info, redirect, busy; receives controls)
// slave : hazard unit side
//   id_valid/id_rs1/id_rs2/id_use_rs1/id_use_rs2/id_rd/id_reg_write/id_is_load : ID decode
//   ex_redirect, ex_busy, mem_busy                                            : pipeline events
//   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en                            : register enables
//   if_id_flush, id_ex_bubble, fwd_rs1_sel, fwd_rs2_sel                        : squash / forwarding
//   stall_cnt, busy_timeout                                                    : status
interface pipe_hazard_unit_if
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  ex_redirect;
    logic                  ex_busy;
    logic                  mem_busy;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    fwd_sel_e              fwd_rs1_sel;
    fwd_sel_e              fwd_rs2_sel;
    logic [CNT_W-1:0]      stall_cnt;
    logic                  busy_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, ex_redirect, ex_busy, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_bubble, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, busy_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, ex_redirect, ex_busy, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_bubble, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, busy_timeout
    );

endinterface

// File: rtl/hazard_cmp.sv
// One source register against one shadow stage: true when the stage holds a
// live, register-writing instruction whose non-x0 rd equals the source.
//   src, src_used : source address and whether it is actually read
//   stage         : shadow stage contents
//   skip_load     : ignore the stage when it holds a load (result not ready yet)
//   match_c       : combinational match
module hazard_cmp
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  shadow_stage_t         stage,
    input  logic                  skip_load,
    output logic                  match_c
);

    assign match_c = src_used & stage.valid & stage.reg_write
                   & ~(skip_load & stage.is_load)
                   & (stage.rd != '0) & (stage.rd == src);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline control for the 5-stage core: shadow EX/MEM/WB destination tracking,
// freeze / redirect / load-use priority, per-stage enables, EX forwarding selects,
// stall-cycle counter and sticky busy timeout.
// Ports: clk, reset (synchronous, active-high), bus (pipe_hazard_unit_if.slave).
// Build option HAZARD_FWD_EN: when defined, EX operands are forwarded and only
// load-use stalls; when undefined, selects stay at the regfile and any RAW against
// EX or MEM stalls until the producer reaches WB.
module pipe_hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_unit_if.slave bus
);

    localparam int unsigned BUSY_W = $clog2(BUSY_TIMEOUT + 1);

    logic              run_q;
    shadow_stage_t     ex_q;
    shadow_stage_t     mem_q;
    shadow_stage_t     id_stage_c;
    logic              active_c;
    logic              busy_c;
    logic              stall_c;
    logic              rs1_used_c;
    logic              rs2_used_c;
    logic              ex_rs1_c;
    logic              ex_rs2_c;
    logic              pc_en_c;
    logic              if_id_en_c;
    logic              id_ex_en_c;
    logic              ex_mem_en_c;
    logic              mem_wb_en_c;
    logic              flush_c;
    logic              bubble_c;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [BUSY_W-1:0] busy_cnt_q;
    logic              timeout_q;

    // run_q holds enables low for the first cycle out of reset
    assign active_c   = run_q & ~reset;
    assign busy_c     = bus.ex_busy | bus.mem_busy;
    assign rs1_used_c = bus.id_valid & bus.id_use_rs1;
    assign rs2_used_c = bus.id_valid & bus.id_use_rs2;
    assign id_stage_c = '{valid: bus.id_valid, rd: bus.id_rd,
                          reg_write: bus.id_reg_write, is_load: bus.id_is_load};

    // ID sources against the instruction in EX
    hazard_cmp u_ex_rs1 (.src(bus.id_rs1), .src_used(rs1_used_c), .stage(ex_q),
                         .skip_load(1'b0), .match_c(ex_rs1_c));
    hazard_cmp u_ex_rs2 (.src(bus.id_rs2), .src_used(rs2_used_c), .stage(ex_q),
                         .skip_load(1'b0), .match_c(ex_rs2_c));

`ifdef HAZARD_FWD_EN
    ex_src_t       ex_src_q;
    ex_src_t       id_src_c;
    shadow_stage_t wb_q;
    logic          mem_fwd1_c;
    logic          mem_fwd2_c;
    logic          wb_fwd1_c;
    logic          wb_fwd2_c;

    assign id_src_c = '{rs1: bus.id_rs1, rs2: bus.id_rs2,
                        use_rs1: bus.id_use_rs1, use_rs2: bus.id_use_rs2};

    // Source tracking for EX and the extra WB stage, only needed for forwarding
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_src_q <= '0;
            wb_q     <= '0;
        end else begin
            if (id_ex_en_c) ex_src_q <= bubble_c ? '0 : id_src_c;
            if (mem_wb_en_c) wb_q <= mem_q;
        end
    end

    // A load in MEM has no result yet, so it cannot feed the EX/MEM path
    hazard_cmp u_mem_fwd1 (.src(ex_src_q.rs1), .src_used(ex_q.valid & ex_src_q.use_rs1),
                           .stage(mem_q), .skip_load(1'b1), .match_c(mem_fwd1_c));
    hazard_cmp u_mem_fwd2 (.src(ex_src_q.rs2), .src_used(ex_q.valid & ex_src_q.use_rs2),
                           .stage(mem_q), .skip_load(1'b1), .match_c(mem_fwd2_c));
    hazard_cmp u_wb_fwd1  (.src(ex_src_q.rs1), .src_used(ex_q.valid & ex_src_q.use_rs1),
                           .stage(wb_q), .skip_load(1'b0), .match_c(wb_fwd1_c));
    hazard_cmp u_wb_fwd2  (.src(ex_src_q.rs2), .src_used(ex_q.valid & ex_src_q.use_rs2),
                           .stage(wb_q), .skip_load(1'b0), .match_c(wb_fwd2_c));

    // Youngest producer wins
    assign bus.fwd_rs1_sel = reset      ? FWD_RF    :
                             mem_fwd1_c ? FWD_EXMEM :
                             wb_fwd1_c  ? FWD_MEMWB : FWD_RF;
    assign bus.fwd_rs2_sel = reset      ? FWD_RF    :
                             mem_fwd2_c ? FWD_EXMEM :
                             wb_fwd2_c  ? FWD_MEMWB : FWD_RF;

    assign stall_c = ex_q.is_load & (ex_rs1_c | ex_rs2_c);
`else
    logic mem_rs1_c;
    logic mem_rs2_c;

    hazard_cmp u_mem_rs1 (.src(bus.id_rs1), .src_used(rs1_used_c), .stage(mem_q),
                          .skip_load(1'b0), .match_c(mem_rs1_c));
    hazard_cmp u_mem_rs2 (.src(bus.id_rs2), .src_used(rs2_used_c), .stage(mem_q),
                          .skip_load(1'b0), .match_c(mem_rs2_c));

    // Without forwarding every producer in EX or MEM blocks its consumer
    assign stall_c = ex_rs1_c | ex_rs2_c | mem_rs1_c | mem_rs2_c;

    assign bus.fwd_rs1_sel = FWD_RF;
    assign bus.fwd_rs2_sel = FWD_RF;
`endif

    // Priority: freeze, redirect, stall, run
    always_comb begin
        pc_en_c     = 1'b0;
        if_id_en_c  = 1'b0;
        id_ex_en_c  = 1'b0;
        ex_mem_en_c = 1'b0;
        mem_wb_en_c = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        if (active_c && !busy_c) begin
            id_ex_en_c  = 1'b1;
            ex_mem_en_c = 1'b1;
            mem_wb_en_c = 1'b1;
            if (bus.ex_redirect) begin
                pc_en_c    = 1'b1;
                if_id_en_c = 1'b1;
                flush_c    = 1'b1;
                bubble_c   = 1'b1;
            end else if (stall_c) begin
                bubble_c   = 1'b1;
            end else begin
                pc_en_c    = 1'b1;
                if_id_en_c = 1'b1;
            end
        end
    end

    // Shadow pipeline advances with the datapath enables
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (id_ex_en_c) ex_q <= bubble_c ? '0 : id_stage_c;
            if (ex_mem_en_c) mem_q <= ex_q;
        end
    end

    // Stall statistics and busy watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            busy_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (active_c && !pc_en_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (busy_c) begin
                if (busy_cnt_q != BUSY_W'(BUSY_TIMEOUT))
                    busy_cnt_q <= busy_cnt_q + BUSY_W'(1);
                if (busy_cnt_q >= BUSY_W'(BUSY_TIMEOUT - 1))
                    timeout_q <= 1'b1;
            end else begin
                busy_cnt_q <= '0;
            end
        end
    end

    assign bus.pc_en        = pc_en_c;
    assign bus.if_id_en     = if_id_en_c;
    assign bus.id_ex_en     = id_ex_en_c;
    assign bus.ex_mem_en    = ex_mem_en_c;
    assign bus.mem_wb_en    = mem_wb_en_c;
    assign bus.if_id_flush  = flush_c;
    assign bus.id_ex_bubble = bubble_c;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.busy_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_pipe_hazard_unit;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;

    pipe_hazard_unit_if #(.CNT_W(32)) bus ();

    pipe_hazard_unit #(.BUSY_TIMEOUT(64), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [4:0] en_vec;
    logic [1:0] ctl;
    assign en_vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
    assign ctl    = {bus.if_id_flush, bus.id_ex_bubble};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                          input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2);
        bus.id_valid     = v;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_rs1       = rs1;
        bus.id_use_rs1   = u1;
        bus.id_rs2       = rs2;
        bus.id_use_rs2   = u2;
    endtask

    task automatic nop_id();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic clear_ctl();
        bus.ex_redirect = 1'b0;
        bus.ex_busy     = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop_id();
        clear_ctl();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop_id();
        clear_ctl();
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (en_vec !== EN_NONE) begin n_err++; $display("FAIL reset_en: got %b want %b", en_vec, EN_NONE); end
        n_cmp++; if (ctl !== 2'b00) begin n_err++; $display("FAIL reset_ctl: got %b want 00", ctl); end
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL reset_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
        n_cmp++; if (bus.busy_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus.busy_timeout); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (en_vec !== EN_NONE) begin n_err++; $display("FAIL first_cycle_en: got %b want %b", en_vec, EN_NONE); end
        tick();
        @(negedge clk);
        n_cmp++; if (en_vec !== EN_ALL) begin n_err++; $display("FAIL run_en: got %b want %b", en_vec, EN_ALL); end
        n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL run_cnt: got %0d want 0", bus.stall_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        reset = 1'b1;
        set_id(1'b1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b1, 5'd1, 1'b1);
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== 7'b0) begin n_err++; $display("FAIL mid_reset_en: got %b want 0000000", {en_vec, ctl}); end
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (en_vec !== EN_ALL) begin n_err++; $display("FAIL mid_reset_discard: got %b want %b", en_vec, EN_ALL); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL mid_reset_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
    endtask

    task automatic test_raw();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (en_vec !== EN_ALL) begin n_err++; $display("FAIL raw_producer_en: got %b want %b", en_vec, EN_ALL); end
        tick();
        set_id(1'b1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b1, 5'd1, 1'b1);
`ifdef HAZARD_FWD_EN
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL raw_nostall: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if (bus.fwd_rs1_sel !== FWD_EXMEM) begin n_err++; $display("FAIL raw_sel1: got %b want 01", bus.fwd_rs1_sel); end
        n_cmp++; if (bus.fwd_rs2_sel !== FWD_EXMEM) begin n_err++; $display("FAIL raw_sel2: got %b want 01", bus.fwd_rs2_sel); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL raw_sel_idle: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL raw_cnt: got %0d want 0", bus.stall_cnt); end
`else
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_LU, 2'b01}) begin n_err++; $display("FAIL raw_stall1: got %b want %b", {en_vec, ctl}, {EN_LU, 2'b01}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_LU, 2'b01}) begin n_err++; $display("FAIL raw_stall2: got %b want %b", {en_vec, ctl}, {EN_LU, 2'b01}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL raw_release: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        n_cmp++; if (bus.stall_cnt !== 32'd2) begin n_err++; $display("FAIL raw_cnt: got %0d want 2", bus.stall_cnt); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL raw_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_LU, 2'b01}) begin n_err++; $display("FAIL lu_stall: got %b want %b", {en_vec, ctl}, {EN_LU, 2'b01}); end
        tick();
`ifdef HAZARD_FWD_EN
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL lu_single_bubble: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        n_cmp++; if (bus.stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if (bus.fwd_rs1_sel !== FWD_MEMWB) begin n_err++; $display("FAIL lu_sel1: got %b want 10", bus.fwd_rs1_sel); end
        n_cmp++; if (bus.fwd_rs2_sel !== FWD_RF) begin n_err++; $display("FAIL lu_sel2: got %b want 00", bus.fwd_rs2_sel); end
`else
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_LU, 2'b01}) begin n_err++; $display("FAIL lu_stall2: got %b want %b", {en_vec, ctl}, {EN_LU, 2'b01}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL lu_release: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        n_cmp++; if (bus.stall_cnt !== 32'd2) begin n_err++; $display("FAIL lu_cnt: got %0d want 2", bus.stall_cnt); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL lu_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
`endif
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        // redirect outranks the load-use on x4
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        bus.ex_redirect = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b11}) begin n_err++; $display("FAIL redir_ctl: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b11}); end
        tick();
        bus.ex_redirect = 1'b0;
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1);
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL redir_squashed: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        tick();
        nop_id();
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL redir_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL redir_cnt: got %0d want 0", bus.stall_cnt); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 34; i++) begin
            bus.ex_busy     = (i < 20);
            bus.mem_busy    = (i >= 20);
            bus.ex_redirect = (i == 10) || (i == 11);
            @(negedge clk);
            n_cmp++; if ({en_vec, ctl} !== 7'b0) begin n_err++; $display("FAIL freeze_cycle%0d: got %b want 0000000", i, {en_vec, ctl}); end
            tick();
        end
        clear_ctl();
        @(negedge clk);
        n_cmp++; if (bus.stall_cnt !== 32'd34) begin n_err++; $display("FAIL freeze_cnt: got %0d want 34", bus.stall_cnt); end
        n_cmp++; if ({en_vec, ctl} !== {EN_LU, 2'b01}) begin n_err++; $display("FAIL freeze_then_lu: got %b want %b", {en_vec, ctl}, {EN_LU, 2'b01}); end
        n_cmp++; if (bus.busy_timeout !== 1'b0) begin n_err++; $display("FAIL freeze_timeout: got %b want 0", bus.busy_timeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.ex_busy = 1'b1;
        repeat (40) tick();
        bus.ex_busy = 1'b0;
        tick();
        bus.mem_busy = 1'b1;
        repeat (40) tick();
        bus.mem_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_not_consecutive: got %b want 0", bus.busy_timeout); end
        tick();
        bus.ex_busy = 1'b1;
        repeat (63) tick();
        @(negedge clk);
        n_cmp++; if (bus.busy_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_at_63: got %b want 0", bus.busy_timeout); end
        tick();
        bus.ex_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_at_64: got %b want 1", bus.busy_timeout); end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (bus.busy_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", bus.busy_timeout); end
        n_cmp++; if (bus.stall_cnt !== 32'd144) begin n_err++; $display("FAIL tmo_cnt: got %0d want 144", bus.stall_cnt); end
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (bus.busy_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_reset: got %b want 0", bus.busy_timeout); end
        reset = 1'b0;
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL x0_nostall: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        tick();
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin n_err++; $display("FAIL x0_sel: got %b%b want 0000", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        tick();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({en_vec, ctl} !== {EN_ALL, 2'b00}) begin n_err++; $display("FAIL x0_load_nostall: got %b want %b", {en_vec, ctl}, {EN_ALL, 2'b00}); end
        n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL x0_cnt: got %0d want 0", bus.stall_cnt); end
        tick();
    endtask

    initial begin
        nop_id();
        clear_ctl();
        test_reset();
        test_reset_mid();
        test_raw();
        test_load_use();
        test_redirect();
        test_freeze();
        test_timeout();
        test_x0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
